// File: rtl/lut_layer_pipe_pkg.sv
// rtl/lut_layer_pipe_pkg.sv - shared parameters, types and helpers for the LUT layer
// Contents: default neuron geometry, per-neuron address type, clog2_min1().
package lut_layer_pkg;

  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_FAN_IN    = 6;
  localparam int DEF_IN_BITS   = 1;
  localparam int DEF_OUT_BITS  = 1;
  localparam int DEF_ADDR_W    = DEF_FAN_IN * DEF_IN_BITS;

  // Truth-table address of one neuron at the default geometry.
  typedef logic [DEF_ADDR_W-1:0] neuron_addr_t;

  // Ceiling log2, never below 1 so a single-neuron layer still has an index bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lut_layer_pipe_if.sv
// rtl/lut_layer_pipe_if.sv - config port and input/output streams of the LUT layer
// master: upstream/downstream/config side; slave: the layer itself.
interface lut_layer_pipe_if
  import lut_layer_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int FAN_IN    = DEF_FAN_IN,
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS
);
  localparam int ADDR_W = FAN_IN * IN_BITS;
  localparam int NIDX_W = clog2_min1(N_NEURONS);

  logic                          cfg_we;
  logic [NIDX_W-1:0]             cfg_neuron;
  logic [ADDR_W-1:0]             cfg_addr;
  logic [OUT_BITS-1:0]           cfg_data;
  logic                          in_valid;
  logic                          in_ready;
  logic [N_NEURONS*ADDR_W-1:0]   in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [N_NEURONS*OUT_BITS-1:0] out_data;

  modport master (
    output cfg_we, cfg_neuron, cfg_addr, cfg_data,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_we, cfg_neuron, cfg_addr, cfg_data,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lut_neuron_ram.sv
// rtl/lut_neuron_ram.sv - one neuron's 2^ADDR_W x DATA_W truth table with registered read
// Ports: clk, rst_n (async, active-low); we/waddr/wdata write port;
//        re/raddr read request; rdata registered lookup result.
module lut_neuron_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples mem_q before this edge's write lands, so a same-cycle
  // write to the looked-up entry returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we) mem_q[waddr] <= wdata;
      if (re) rdata_q <= mem_q[raddr];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_pipe.sv
// rtl/lut_layer_pipe.sv - two-stage pipelined layer of runtime-loadable LUT neurons
// Ports: clk; rst_n (async, active-low); bus (lut_layer_pipe_if.slave) carrying
//        the config write port, the input stream and the output stream.
module lut_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int FAN_IN    = DEF_FAN_IN,
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  lut_layer_pipe_if.slave  bus
);
  localparam int ADDR_W = FAN_IN * IN_BITS;
  localparam int NIDX_W = clog2_min1(N_NEURONS);

  logic                        s1_valid_q, s1_valid_d;
  logic [N_NEURONS*ADDR_W-1:0] s1_data_q, s1_data_d;
  logic                        s2_valid_q, s2_valid_d;
  logic                        s1_adv, s2_adv, rd_en;
  logic [N_NEURONS*OUT_BITS-1:0] lut_word;

  // A stage advances when it is empty or the stage after it advances;
  // in_ready therefore never depends on in_valid.
  assign s2_adv = !s2_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign rd_en  = s2_adv && s1_valid_q;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = lut_word;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) s1_data_d = bus.in_data;
    end
    if (s2_adv) s2_valid_d = s1_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Each table holds the S2 data register for its neuron; an out-of-range
  // cfg_neuron matches no k and so writes nothing.
  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    logic                wr_en;
    logic [OUT_BITS-1:0] rdata;

    assign wr_en = bus.cfg_we && (bus.cfg_neuron == NIDX_W'(k));

    lut_neuron_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (OUT_BITS)
    ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_en),
      .waddr   (bus.cfg_addr),
      .wdata   (bus.cfg_data),
      .re      (rd_en),
      .raddr   (s1_data_q[k*ADDR_W +: ADDR_W]),
      .rdata_o (rdata)
    );

    assign lut_word[k*OUT_BITS +: OUT_BITS] = rdata;
  end

endmodule

// File: tb/tb_lut_layer_pipe.sv
// tb/tb_lut_layer_pipe.sv - self-checking bench for lut_layer_pipe
module tb_lut_layer_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference truth tables for the 4-neuron instance.
  logic model [4][64];

  always #5 clk = ~clk;

  lut_layer_pipe_if #(.N_NEURONS(4), .FAN_IN(6), .IN_BITS(1), .OUT_BITS(1)) bus ();
  lut_layer_pipe_if #(.N_NEURONS(3), .FAN_IN(6), .IN_BITS(1), .OUT_BITS(1)) bus3 ();

  lut_layer_pipe #(.N_NEURONS(4), .FAN_IN(6), .IN_BITS(1), .OUT_BITS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  lut_layer_pipe #(.N_NEURONS(3), .FAN_IN(6), .IN_BITS(1), .OUT_BITS(1)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_lookup(input logic [23:0] w);
    logic [3:0] r;
    logic [5:0] a;
    for (int k = 0; k < 4; k++) begin
      a = w[k*6 +: 6];
      r[k] = model[k][a];
    end
    return r;
  endfunction

  task automatic cfg_write(input int n, input int a, input logic d);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = 2'(n);
    bus.cfg_addr   = 6'(a);
    bus.cfg_data   = d;
    tick();
    bus.cfg_we = 1'b0;
    model[n][a] = d;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%b data=%b expected valid=0 data=0000", bus.out_valid, bus.out_data);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus3.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", bus.in_ready, bus3.in_ready);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus3.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_valid: got %b/%b expected 0/0", bus.out_valid, bus3.out_valid);
    end
  endtask

  task automatic test_load_lookup();
    logic [23:0] w;
    cfg_write(0, 6'b110000, 1'b1);
    cfg_write(3, 6'b111111, 1'b1);
    w = {6'b111111, 6'd0, 6'd0, 6'b110000};
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_handshake: got in_ready=%b expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_early_valid: got %b expected 0", bus.out_valid);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b1001) begin
      n_fail++;
      $display("FAIL load_lookup: got valid=%b data=%b expected valid=1 data=1001", bus.out_valid, bus.out_data);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_single_word: got valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [23:0] words [16];
    logic        exp_v;
    for (int a = 0; a < 64; a++) cfg_write(0, a, a[0]);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i < 16) begin
        words[i] = 24'(i);
        bus.in_valid = 1'b1;
        bus.in_data  = words[i];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (i < 16) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
        end
      end
      exp_v = (i >= 2) && (i < 18);
      n_checks++;
      if (bus.out_valid !== exp_v) begin
        n_fail++;
        $display("FAIL stream_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_v);
      end else if (exp_v) begin
        n_checks++;
        if (bus.out_data !== ref_lookup(words[i-2]) || bus.out_data[0] !== 1'((i - 2) & 1)) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: got %b expected %b", i, bus.out_data, ref_lookup(words[i-2]));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] w [4];
    logic [3:0]  exp_q [$];
    logic [3:0]  e;
    logic [3:0]  held;
    int          idx = 0;
    int          got = 0;
    logic        stable = 1'b1;
    for (int i = 0; i < 4; i++) w[i] = 24'($urandom);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (idx < 4);
      if (idx < 4) bus.in_data = w[idx];
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_lookup(w[idx]));
        idx++;
      end
      tick();
    end
    n_checks++;
    if (idx !== 2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_capacity: got accepted=%0d in_ready=%b out_valid=%b expected 2/0/1", idx, bus.in_ready, bus.out_valid);
    end
    held = bus.out_data;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.out_data !== held || bus.out_valid !== 1'b1) stable = 1'b0;
    end
    n_checks++;
    if (!stable || held !== exp_q[0]) begin
      n_fail++;
      $display("FAIL bp_hold: got held=%b now=%b expected %b", held, bus.out_data, exp_q[0]);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      bus.in_valid = (idx < 4);
      if (idx < 4) bus.in_data = w[idx];
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_lookup(w[idx]));
        idx++;
      end
      if (bus.out_valid) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra_word: got %b expected none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: got %b expected %b", got - 1, bus.out_data, e);
          end
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (got !== 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words expected 4", got);
    end
  endtask

  task automatic test_collision();
    logic [23:0] w;
    logic [3:0]  e_old;
    w = 24'(5) << 6;
    e_old = ref_lookup(w);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    tick();
    bus.in_valid   = 1'b0;
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = 2'd1;
    bus.cfg_addr   = 6'd5;
    bus.cfg_data   = 1'b1;
    tick();
    bus.cfg_we = 1'b0;
    model[1][5] = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== e_old || bus.out_data[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_old: got valid=%b data=%b expected valid=1 data=%b", bus.out_valid, bus.out_data, e_old);
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ref_lookup(w) || bus.out_data[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_new: got valid=%b data=%b expected valid=1 data=%b", bus.out_valid, bus.out_data, ref_lookup(w));
    end
  endtask

  task automatic test_random_stream();
    logic [23:0] w;
    logic [3:0]  exp_q [$];
    logic [3:0]  e;
    logic [3:0]  prev_data = '0;
    logic        prev_stall = 1'b0;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    for (int i = 0; i < 40; i++)
      cfg_write($urandom_range(0, 3), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
    w = 24'($urandom);
    while ((sent < 60 || got < sent) && cyc < 600) begin
      bus.in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
      bus.in_data   = w;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          n_fail++;
          $display("FAIL rand_stable[%0d]: got %b expected %b", cyc, bus.out_data, prev_data);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_lookup(w));
        sent++;
        w = 24'($urandom);
      end
      if (bus.out_valid && bus.out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra_word: got %b expected none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            n_fail++;
            $display("FAIL rand_data[%0d]: got %b expected %b", got - 1, bus.out_data, e);
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (got !== 60 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d words expected 60 (cycles %0d)", got, cyc);
    end
  endtask

  task automatic test_illegal_cfg();
    logic [17:0] w;
    for (int a = 0; a < 64; a++) begin
      bus3.cfg_we     = 1'b1;
      bus3.cfg_neuron = 2'd3;
      bus3.cfg_addr   = 6'(a);
      bus3.cfg_data   = 1'b1;
      tick();
    end
    bus3.cfg_we    = 1'b0;
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = 18'($urandom);
      if (i == 0) w = '1;
      bus3.in_valid = 1'b1;
      bus3.in_data  = w;
      tick();
      bus3.in_valid = 1'b0;
      tick();
      n_checks++;
      if (bus3.out_valid !== 1'b1 || bus3.out_data !== 3'b000) begin
        n_fail++;
        $display("FAIL illegal_cfg[%0d]: got valid=%b data=%b expected valid=1 data=000", i, bus3.out_valid, bus3.out_data);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] w;
    cfg_write(2, 7, 1'b1);
    w = 24'(7) << 12;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ref_lookup(w)) begin
      n_fail++;
      $display("FAIL arst_setup: got valid=%b data=%b expected valid=1 data=%b", bus.out_valid, bus.out_data, ref_lookup(w));
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'b0000) begin
      n_fail++;
      $display("FAIL arst_immediate: got valid=%b data=%b expected valid=0 data=0000", bus.out_valid, bus.out_data);
    end
    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 64; a++) model[n][a] = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_discard: got valid=%b expected 0", bus.out_valid);
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0000) begin
      n_fail++;
      $display("FAIL arst_tables_cleared: got valid=%b data=%b expected valid=1 data=0000", bus.out_valid, bus.out_data);
    end
  endtask

  initial begin
    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 64; a++) model[n][a] = 1'b0;
    bus.cfg_we = 1'b0;  bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;   bus.out_ready = 1'b0;
    bus3.cfg_we = 1'b0; bus3.cfg_neuron = '0; bus3.cfg_addr = '0; bus3.cfg_data = '0;
    bus3.in_valid = 1'b0; bus3.in_data = '0;  bus3.out_ready = 1'b0;

    test_reset();
    test_load_lookup();
    test_streaming();
    test_backpressure();
    test_collision();
    test_random_stream();
    test_illegal_cfg();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
